pll_dyn_ctrl: RTL and testbench

Sequencer that drives the Gowin PLL's dynamic-configuration ports (divider selects, PLL reset) and supervises its LOCK output. It sits in the PLL input-clock domain next to the SNES clock PLL. It applies new divider settings on request, holds the PLL in reset, waits for a qualified lock with timeout, and reports status to the rest of the core.

---
 rtl/pll_dyn_ctrl.sv | 210 +++++++++++++++++++++
 tb/tb_pll_dyn_ctrl.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/pll_dyn_ctrl.sv
// Dynamic-configuration sequencer for the Gowin PLL: applies divider selects, pulses RESET, qualifies LOCK.
// Optional build macro PLL_AUTO_RELOCK_EN: re-run the sequence automatically after lock loss in IDLE.
module pll_dyn_ctrl #(
    parameter int         RST_CYCLES    = 16,
    parameter int         SETTLE_CYCLES = 8,
    parameter int         LOCK_TIMEOUT  = 270000,
    parameter int         STABLE_CYCLES = 1024,
    parameter logic [5:0] DEF_IDSEL     = 6'd0,
    parameter logic [6:0] DEF_MDSEL     = 7'd0,
    parameter logic [6:0] DEF_ODSEL0    = 7'd0
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       req,
    input  logic [5:0] cfg_idsel,
    input  logic [6:0] cfg_mdsel,
    input  logic [6:0] cfg_odsel0,
    input  logic       pll_lock,
    output logic       pll_reset,
    output logic [5:0] idsel,
    output logic [6:0] mdsel,
    output logic [6:0] odsel0,
    output logic       busy,
    output logic       locked,
    output logic       done,
    output logic       timeout_err
);
    // state      | meaning
    // ST_RST     | PLL RESET held high for RST_CYCLES
    // ST_SETTLE  | RESET released, wait SETTLE_CYCLES before looking at lock
    // ST_WAIT    | waiting for synchronized lock, timeout running
    // ST_STABLE  | counting consecutive lock-high cycles, timeout still running
    // ST_IDLE    | sequence finished (locked or timed out), accepts req
    typedef enum logic [2:0] {ST_RST, ST_SETTLE, ST_WAIT, ST_STABLE, ST_IDLE} state_t;

    localparam int PH_MAX = (RST_CYCLES > SETTLE_CYCLES) ? RST_CYCLES : SETTLE_CYCLES;
    localparam int PH_W   = $clog2(PH_MAX) + 1;
    localparam int TMO_W  = $clog2(LOCK_TIMEOUT) + 1;
    localparam int STB_W  = $clog2(STABLE_CYCLES) + 1;

    localparam logic [PH_W-1:0]  RST_TC = PH_W'(RST_CYCLES - 1);
    localparam logic [PH_W-1:0]  SET_TC = PH_W'(SETTLE_CYCLES - 1);
    localparam logic [TMO_W-1:0] TMO_TC = TMO_W'(LOCK_TIMEOUT - 1);
    localparam logic [STB_W-1:0] STB_TC = STB_W'(STABLE_CYCLES - 1);

    state_t           state, state_nxt;
    logic [PH_W-1:0]  ph_cnt, ph_nxt;
    logic [TMO_W-1:0] tmo_cnt, tmo_nxt;
    logic [STB_W-1:0] stb_cnt, stb_nxt;
    logic [5:0]       idsel_q, idsel_nxt;
    logic [6:0]       mdsel_q, mdsel_nxt;
    logic [6:0]       odsel0_q, odsel0_nxt;
    logic             locked_q, locked_nxt;
    logic             done_q, done_nxt;
    logic             terr_q, terr_nxt;
    logic             lock_meta, lock_s;
`ifdef PLL_AUTO_RELOCK_EN
    logic             relock_q, relock_nxt;
`endif

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            lock_meta <= 1'b0;
            lock_s    <= 1'b0;
        end else begin
            lock_meta <= pll_lock;
            lock_s    <= lock_meta;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state    <= ST_RST;
            ph_cnt   <= '0;
            tmo_cnt  <= '0;
            stb_cnt  <= '0;
            idsel_q  <= DEF_IDSEL;
            mdsel_q  <= DEF_MDSEL;
            odsel0_q <= DEF_ODSEL0;
            locked_q <= 1'b0;
            done_q   <= 1'b0;
            terr_q   <= 1'b0;
`ifdef PLL_AUTO_RELOCK_EN
            relock_q <= 1'b0;
`endif
        end else begin
            state    <= state_nxt;
            ph_cnt   <= ph_nxt;
            tmo_cnt  <= tmo_nxt;
            stb_cnt  <= stb_nxt;
            idsel_q  <= idsel_nxt;
            mdsel_q  <= mdsel_nxt;
            odsel0_q <= odsel0_nxt;
            locked_q <= locked_nxt;
            done_q   <= done_nxt;
            terr_q   <= terr_nxt;
`ifdef PLL_AUTO_RELOCK_EN
            relock_q <= relock_nxt;
`endif
        end
    end

    always_comb begin
        state_nxt  = state;
        ph_nxt     = ph_cnt;
        tmo_nxt    = tmo_cnt;
        stb_nxt    = stb_cnt;
        idsel_nxt  = idsel_q;
        mdsel_nxt  = mdsel_q;
        odsel0_nxt = odsel0_q;
        locked_nxt = locked_q;
        done_nxt   = 1'b0;
        terr_nxt   = terr_q;
`ifdef PLL_AUTO_RELOCK_EN
        relock_nxt = relock_q;
`endif
        case (state)
            ST_RST: begin
                if (ph_cnt == RST_TC) begin
                    state_nxt = ST_SETTLE;
                    ph_nxt    = '0;
                end else begin
                    ph_nxt = ph_cnt + PH_W'(1);
                end
            end
            ST_SETTLE: begin
                if (ph_cnt == SET_TC) begin
                    state_nxt = ST_WAIT;
                    ph_nxt    = '0;
                    tmo_nxt   = '0;
                end else begin
                    ph_nxt = ph_cnt + PH_W'(1);
                end
            end
            ST_WAIT: begin
                if (tmo_cnt == TMO_TC) begin
                    state_nxt  = ST_IDLE;
                    terr_nxt   = 1'b1;
                    locked_nxt = 1'b0;
                end else begin
                    tmo_nxt = tmo_cnt + TMO_W'(1);
                    if (lock_s) begin
                        state_nxt = ST_STABLE;
                        stb_nxt   = '0;
                    end
                end
            end
            ST_STABLE: begin
                // a qualification landing on the last timeout cycle still counts as success
                if (lock_s && stb_cnt == STB_TC) begin
                    state_nxt  = ST_IDLE;
                    locked_nxt = 1'b1;
                    done_nxt   = 1'b1;
                end else if (tmo_cnt == TMO_TC) begin
                    state_nxt  = ST_IDLE;
                    terr_nxt   = 1'b1;
                    locked_nxt = 1'b0;
                end else begin
                    tmo_nxt = tmo_cnt + TMO_W'(1);
                    if (!lock_s) begin
                        state_nxt = ST_WAIT;
                        stb_nxt   = '0;
                    end else begin
                        stb_nxt = stb_cnt + STB_W'(1);
                    end
                end
            end
            ST_IDLE: begin
                if (req) begin
                    state_nxt  = ST_RST;
                    ph_nxt     = '0;
                    idsel_nxt  = cfg_idsel;
                    mdsel_nxt  = cfg_mdsel;
                    odsel0_nxt = cfg_odsel0;
                    locked_nxt = 1'b0;
                    terr_nxt   = 1'b0;
`ifdef PLL_AUTO_RELOCK_EN
                    relock_nxt = 1'b0;
`endif
                end else if (locked_q && !lock_s) begin
                    locked_nxt = 1'b0;
`ifdef PLL_AUTO_RELOCK_EN
                    relock_nxt = 1'b1;
`endif
                end
`ifdef PLL_AUTO_RELOCK_EN
                // relock leaves IDLE one cycle after locked falls
                else if (relock_q) begin
                    state_nxt  = ST_RST;
                    ph_nxt     = '0;
                    relock_nxt = 1'b0;
                end
`endif
            end
            default: begin
                state_nxt = ST_RST;
                ph_nxt    = '0;
            end
        endcase
    end

    assign pll_reset   = (state == ST_RST);
    assign busy        = (state != ST_IDLE);
    assign idsel       = idsel_q;
    assign mdsel       = mdsel_q;
    assign odsel0      = odsel0_q;
    assign locked      = locked_q;
    assign done        = done_q;
    assign timeout_err = terr_q;
endmodule

// File: tb/tb_pll_dyn_ctrl.sv
// Directed bench for pll_dyn_ctrl; cycle indices are negedges counted from the stimulus point
// (index 0 = negedge after the accepting edge, or the reset-release negedge for power-up).
module tb_pll_dyn_ctrl;
    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       req = 1'b0, req_t = 1'b0;
    logic [5:0] cfg_idsel = '0;
    logic [6:0] cfg_mdsel = '0, cfg_odsel0 = '0;
    logic       pll_lock = 1'b0, pll_lock_t = 1'b0;
    logic       pll_reset, busy, locked, done, timeout_err;
    logic [5:0] idsel;
    logic [6:0] mdsel, odsel0;
    logic       pll_reset_t, busy_t, locked_t, done_t, timeout_err_t;
    logic [5:0] idsel_t;
    logic [6:0] mdsel_t, odsel0_t;
    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    pll_dyn_ctrl dut (
        .clk(clk), .resetn(resetn), .req(req), .cfg_idsel(cfg_idsel), .cfg_mdsel(cfg_mdsel),
        .cfg_odsel0(cfg_odsel0), .pll_lock(pll_lock), .pll_reset(pll_reset), .idsel(idsel),
        .mdsel(mdsel), .odsel0(odsel0), .busy(busy), .locked(locked), .done(done),
        .timeout_err(timeout_err)
    );

    pll_dyn_ctrl #(.LOCK_TIMEOUT(500)) dut_t (
        .clk(clk), .resetn(resetn), .req(req_t), .cfg_idsel(cfg_idsel), .cfg_mdsel(cfg_mdsel),
        .cfg_odsel0(cfg_odsel0), .pll_lock(pll_lock_t), .pll_reset(pll_reset_t), .idsel(idsel_t),
        .mdsel(mdsel_t), .odsel0(odsel0_t), .busy(busy_t), .locked(locked_t), .done(done_t),
        .timeout_err(timeout_err_t)
    );

    // Walks one sequence on dut, optionally raising pll_lock or dropping it for b_len cycles.
    task automatic run_seq(input int lock_on, input int b_at, input int b_len, input int limit,
                           input logic [19:0] exp_sel, output int rst_len, output int done_at,
                           output int done_cnt, output logic lk_at_done, output logic lk_before,
                           output int sel_bad);
        rst_len = -1; done_at = -1; done_cnt = 0; lk_at_done = 1'b0; lk_before = 1'b1; sel_bad = 0;
        for (int i = 0; i < limit; i++) begin
            if (i == lock_on) pll_lock = 1'b1;
            if (i == b_at) pll_lock = 1'b0;
            if (i == b_at + b_len) pll_lock = 1'b1;
            if (rst_len < 0 && !pll_reset) rst_len = i;
            if ({idsel, mdsel, odsel0} !== exp_sel) sel_bad++;
            if (done_at < 0 && done !== 1'b1) lk_before = locked;
            if (done === 1'b1) begin
                done_cnt++;
                if (done_at < 0) begin
                    done_at = i;
                    lk_at_done = locked;
                end
            end
            if (done_at >= 0 && i >= done_at + 4) break;
            @(negedge clk);
        end
    endtask

    task automatic check_seq(input string tag, input int rl, input int da, input int dc,
                             input logic la, input logic lb, input int sb, input int exp_da);
        total++; if (rl !== 16) begin bad++; $display("FAIL %s_rst_len: got %0d want 16", tag, rl); end
        total++; if (da !== exp_da) begin bad++; $display("FAIL %s_done_at: got %0d want %0d", tag, da, exp_da); end
        total++; if (dc !== 1) begin bad++; $display("FAIL %s_done_count: got %0d want 1", tag, dc); end
        total++; if (la !== 1'b1) begin bad++; $display("FAIL %s_locked_at_done: got %0b want 1", tag, la); end
        total++; if (lb !== 1'b0) begin bad++; $display("FAIL %s_locked_before_done: got %0b want 0", tag, lb); end
        total++; if (sb !== 0) begin bad++; $display("FAIL %s_selects_stable: got %0d bad samples want 0", tag, sb); end
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        pll_lock = 1'b0;
        repeat (3) @(negedge clk);
        total++; if ({pll_reset, busy, locked, done, timeout_err} !== 5'b11000) begin
            bad++; $display("FAIL reset_flags: got %b want 11000", {pll_reset, busy, locked, done, timeout_err}); end
        total++; if ({idsel, mdsel, odsel0} !== 20'h0) begin
            bad++; $display("FAIL reset_selects: got %h want 00000", {idsel, mdsel, odsel0}); end
        total++; if ({pll_reset_t, busy_t, locked_t, done_t, timeout_err_t} !== 5'b11000) begin
            bad++; $display("FAIL reset_flags_t: got %b want 11000", {pll_reset_t, busy_t, locked_t, done_t, timeout_err_t}); end
    endtask

    task automatic test_power_up();
        int rl, da, dc, sb;
        logic la, lb;
        @(negedge clk);
        resetn = 1'b1;
        // lock at idx 40 -> lock_s at edge 42 -> STABLE at 43 -> 1024 counts -> done at 1067
        run_seq(40, -1, 0, 3000, 20'h0, rl, da, dc, la, lb, sb);
        check_seq("pwr", rl, da, dc, la, lb, sb, 1067);
    endtask

    task automatic test_reconfig();
        int rl, da, dc, sb;
        logic la, lb;
        total++; if (locked !== 1'b1 || busy !== 1'b0) begin
            bad++; $display("FAIL cfg_pre_idle: got locked=%0b busy=%0b want 1 0", locked, busy); end
        req = 1'b1; cfg_idsel = 6'd3; cfg_mdsel = 7'd40; cfg_odsel0 = 7'd10;
        total++; if ({idsel, mdsel, odsel0} !== 20'h0) begin
            bad++; $display("FAIL cfg_sel_before_edge: got %h want 00000", {idsel, mdsel, odsel0}); end
        @(negedge clk);
        req = 1'b0;
        total++; if ({idsel, mdsel, odsel0} !== {6'd3, 7'd40, 7'd10}) begin
            bad++; $display("FAIL cfg_sel_captured: got %0d/%0d/%0d want 3/40/10", idsel, mdsel, odsel0); end
        total++; if ({locked, pll_reset, busy} !== 3'b011) begin
            bad++; $display("FAIL cfg_start_flags: got %b want 011", {locked, pll_reset, busy}); end
        // RST idx 0..15, SETTLE 16..23, WAIT at edge 24, STABLE from edge 25, done at 25+1024
        run_seq(-1, -1, 0, 3000, {6'd3, 7'd40, 7'd10}, rl, da, dc, la, lb, sb);
        check_seq("cfg", rl, da, dc, la, lb, sb, 1049);
    endtask

    task automatic test_bounce();
        int rl, da, dc, sb;
        logic la, lb;
        req = 1'b1; cfg_idsel = 6'd5; cfg_mdsel = 7'd20; cfg_odsel0 = 7'd2;
        @(negedge clk);
        req = 1'b0;
        // drop at stable count 1000 (idx 1025) for 5 cycles: back to WAIT at 1028,
        // STABLE again at edge 1033, done 1024 edges later
        run_seq(-1, 1025, 5, 4000, {6'd5, 7'd20, 7'd2}, rl, da, dc, la, lb, sb);
        check_seq("bnc", rl, da, dc, la, lb, sb, 2057);
    endtask

    task automatic test_lock_loss();
        int n;
        total++; if (locked !== 1'b1 || busy !== 1'b0) begin
            bad++; $display("FAIL loss_pre_idle: got locked=%0b busy=%0b want 1 0", locked, busy); end
        pll_lock = 1'b0;
        repeat (2) @(negedge clk);
        total++; if (locked !== 1'b1) begin bad++; $display("FAIL loss_locked_at_2: got %0b want 1", locked); end
        @(negedge clk);
        total++; if (locked !== 1'b0 || busy !== 1'b0) begin
            bad++; $display("FAIL loss_locked_at_3: got locked=%0b busy=%0b want 0 0", locked, busy); end
        @(negedge clk);
`ifdef PLL_AUTO_RELOCK_EN
        total++; if (pll_reset !== 1'b1 || busy !== 1'b1) begin
            bad++; $display("FAIL loss_relock_start: got rst=%0b busy=%0b want 1 1", pll_reset, busy); end
        pll_lock = 1'b1;
        n = 0;
        while (done !== 1'b1 && n < 3000) begin @(negedge clk); n++; end
        total++; if (done !== 1'b1 || locked !== 1'b1) begin
            bad++; $display("FAIL loss_relock_done: got done=%0b locked=%0b want 1 1", done, locked); end
        repeat (2) @(negedge clk);
`else
        total++; if (pll_reset !== 1'b0 || busy !== 1'b0) begin
            bad++; $display("FAIL loss_stay_idle: got rst=%0b busy=%0b want 0 0", pll_reset, busy); end
        pll_lock = 1'b1;
        n = 0;
        repeat (10) begin @(negedge clk); if (busy !== 1'b0 || locked !== 1'b0) n++; end
        total++; if (n !== 0) begin bad++; $display("FAIL loss_idle_hold: got %0d bad samples want 0", n); end
`endif
    endtask

    task automatic test_timeout();
        int idx;
        logic terr_prev;
        total++; if ({timeout_err_t, locked_t, busy_t} !== 3'b100) begin
            bad++; $display("FAIL tmo_initial: got %b want 100", {timeout_err_t, locked_t, busy_t}); end
        req_t = 1'b1;
        @(negedge clk);
        req_t = 1'b0;
        total++; if (timeout_err_t !== 1'b0 || pll_reset_t !== 1'b1) begin
            bad++; $display("FAIL tmo_req_clears: got terr=%0b rst=%0b want 0 1", timeout_err_t, pll_reset_t); end
        // WAIT entered at edge 24, 500 cycles there -> IDLE at idx 524
        idx = 0; terr_prev = 1'b1;
        while (busy_t !== 1'b0 && idx < 2000) begin
            terr_prev = timeout_err_t;
            @(negedge clk); idx++;
        end
        total++; if (idx !== 524) begin bad++; $display("FAIL tmo_busy_fall: got %0d want 524", idx); end
        total++; if ({timeout_err_t, locked_t, done_t} !== 3'b100) begin
            bad++; $display("FAIL tmo_flags: got %b want 100", {timeout_err_t, locked_t, done_t}); end
        total++; if (terr_prev !== 1'b0) begin bad++; $display("FAIL tmo_err_early: got %0b want 0", terr_prev); end
    endtask

    task automatic test_busy_req_and_reset();
        req = 1'b1; cfg_idsel = 6'd7; cfg_mdsel = 7'd50; cfg_odsel0 = 7'd3;
        @(negedge clk);
        req = 1'b0;
        repeat (5) @(negedge clk);
        req = 1'b1; cfg_idsel = 6'd1; cfg_mdsel = 7'd2; cfg_odsel0 = 7'd3;
        @(negedge clk);
        req = 1'b0;
        total++; if ({idsel, mdsel, odsel0} !== {6'd7, 7'd50, 7'd3}) begin
            bad++; $display("FAIL busy_req_ignored: got %0d/%0d/%0d want 7/50/3", idsel, mdsel, odsel0); end
        repeat (94) @(negedge clk);
        total++; if (busy !== 1'b1 || pll_reset !== 1'b0 || {idsel, mdsel, odsel0} !== {6'd7, 7'd50, 7'd3}) begin
            bad++; $display("FAIL busy_mid_stable: got busy=%0b rst=%0b sel=%h want 1 0 %h",
                            busy, pll_reset, {idsel, mdsel, odsel0}, {6'd7, 7'd50, 7'd3}); end
        resetn = 1'b0;
        #1;
        total++; if ({pll_reset, busy, locked, done, timeout_err} !== 5'b11000) begin
            bad++; $display("FAIL midreset_flags: got %b want 11000", {pll_reset, busy, locked, done, timeout_err}); end
        total++; if ({idsel, mdsel, odsel0} !== 20'h0) begin
            bad++; $display("FAIL midreset_selects: got %h want 00000", {idsel, mdsel, odsel0}); end
        repeat (3) @(negedge clk);
        resetn = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_power_up();
        test_reconfig();
        test_bounce();
        test_lock_loss();
        test_timeout();
        test_busy_req_and_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
